// File: rtl/hilo_divider_unit.sv
// HI/LO register pair with a single-cycle multiplier and a 32-step radix-2
// restoring divider for the execute stage; stalls the pipeline while dividing.
module hilo_divider_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hl_we,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall_o,
  output logic             busy_o
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_a_raw;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;
  logic [CNT_W-1:0] r_cnt;

  logic               w_is_div_op;
  logic               w_signed_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_mul_sx;
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_is_div_op  = hl_we && ((funct == F_DIV) || (funct == F_DIVU));
  assign w_signed_div = (funct == F_DIV);
  assign w_a_neg      = w_signed_div && src_a[WIDTH-1];
  assign w_b_neg      = w_signed_div && src_b[WIDTH-1];
  assign w_a_mag      = w_a_neg ? -src_a : src_a;
  assign w_b_mag      = w_b_neg ? -src_b : src_b;

  // Low 2*WIDTH bits of a product are sign-agnostic once the operands are
  // extended to full width, so one multiplier serves MULT and MULTU.
  assign w_mul_sx = (funct == F_MULT);
  assign w_mul_a  = {{WIDTH{w_mul_sx & src_a[WIDTH-1]}}, src_a};
  assign w_mul_b  = {{WIDTH{w_mul_sx & src_b[WIDTH-1]}}, src_b};
  assign w_prod   = w_mul_a * w_mul_b;

  // Dividend bits shift out of r_quo's MSB while quotient bits shift in at its LSB.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};

  assign w_quo_fix = r_q_neg ? -r_quo : r_quo;
  assign w_rem_fix = r_r_neg ? -r_rem : r_rem;

  assign hi_o    = r_hi;
  assign lo_o    = r_lo;
  assign busy_o  = (r_state != S_IDLE);
  assign stall_o = !flush && (((r_state == S_IDLE) && w_is_div_op) || (r_state == S_RUN));

  // NOTE: every register here is updated with <= so all reads in this block see
  // pre-edge values; the divider working registers are reset too, keeping an
  // aborted divide from leaving stale state behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_a_raw <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hl_we) begin
            case (funct)
              F_MTHI: r_hi <= src_a;
              F_MTLO: r_lo <= src_a;
              F_MULT, F_MULTU: begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
              end
              F_DIV, F_DIVU: begin
                r_quo   <= w_a_mag;
                r_dvs   <= w_b_mag;
                r_rem   <= '0;
                r_a_raw <= src_a;
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
                r_dz    <= (src_b == '0);
                r_cnt   <= '0;
                r_state <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_dz) begin
            r_lo <= '1;
            r_hi <= r_a_raw;
          end else begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_divider_unit.sv
// Directed bench for hilo_divider_unit: moves, multiplies, divides, divide by
// zero, the signed overflow corner, flush abort and reset mid-divide.
module tb_hilo_divider_unit;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk;
  logic        resetn;
  logic        hl_we;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_divider_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hl_we  (hl_we),
    .funct  (funct),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .hi_o   (hi_o),
    .lo_o   (lo_o),
    .stall_o(stall_o),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic we, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    hl_we = we;
    funct = f;
    src_a = a;
    src_b = b;
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi_o, lo_o);
    end
    n_tests++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: stall=%b busy=%b expected 0/0", stall_o, busy_o);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_moves();
    drive(1'b1, F_MTHI, 32'h12345678, 32'h0);
    n_tests++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_stall: stall=%b expected 0", stall_o);
    end
    drive(1'b1, F_MTLO, 32'h9abcdef0, 32'h0);
    n_tests++;
    if (hi_o !== 32'h12345678 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi: hi=%h stall=%b expected 12345678/0", hi_o, stall_o);
    end
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    n_tests++;
    if (lo_o !== 32'h9abcdef0 || hi_o !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mtlo: hi=%h lo=%h expected 12345678/9abcdef0", hi_o, lo_o);
    end
    // A write-enable with an unrelated funct (MFHI) must not disturb HI/LO.
    drive(1'b1, 6'h10, 32'hdeadbeef, 32'hdeadbeef);
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    n_tests++;
    if (hi_o !== 32'h12345678 || lo_o !== 32'h9abcdef0) begin
      n_fail++;
      $display("FAIL other_funct: hi=%h lo=%h expected 12345678/9abcdef0", hi_o, lo_o);
    end
  endtask

  task automatic test_multiply();
    drive(1'b1, F_MULT, 32'hFFFFFFFE, 32'h00000003);
    drive(1'b1, F_MULTU, 32'hFFFFFFFE, 32'h00000003);
    n_tests++;
    if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFA || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mult: hi=%h lo=%h stall=%b expected ffffffff/fffffffa/0", hi_o, lo_o, stall_o);
    end
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    n_tests++;
    if (hi_o !== 32'h00000002 || lo_o !== 32'hFFFFFFFA) begin
      n_fail++;
      $display("FAIL multu: hi=%h lo=%h expected 00000002/fffffffa", hi_o, lo_o);
    end
  endtask

  // Issues a divide, holds hl_we through DONE, scrambles the operands during
  // RUN, then checks stall length, no restart, and the result.
  task automatic run_div(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int stalls;
    int guard;
    drive(1'b1, f, a, b);
    stalls = 0;
    guard  = 0;
    while (stall_o === 1'b1 && guard < 100) begin
      stalls++;
      guard++;
      @(negedge clk);
      src_a = 32'hDEADBEEF;
      src_b = 32'h00000001;
      #1;
    end
    n_tests++;
    if (stalls != 33) begin
      n_fail++;
      $display("FAIL %s_stall: stall cycles=%0d expected 33", name, stalls);
    end
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_norestart: busy=%b expected 0", name, busy_o);
    end
    n_tests++;
    if (lo_o !== exp_lo || hi_o !== exp_hi) begin
      n_fail++;
      $display("FAIL %s_result: lo=%h hi=%h expected %h/%h", name, lo_o, hi_o, exp_lo, exp_hi);
    end
  endtask

  task automatic test_divide();
    run_div("div_m7_2",   F_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu_100_7", F_DIVU, 32'd100,      32'd7,        32'd14,       32'd2);
    run_div("div_7_m2",   F_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
  endtask

  task automatic test_div_corners();
    run_div("divu_by0",    F_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5);
    run_div("div_m7_by0",  F_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9);
    run_div("div_min_m1",  F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
  endtask

  task automatic test_flush();
    drive(1'b1, F_MTHI, 32'hAA, 32'h0);
    drive(1'b1, F_MTLO, 32'hAA, 32'h0);
    drive(1'b1, F_DIV, 32'd50, 32'd5);
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    n_tests++;
    if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_stall: stall=%b busy=%b expected 0/1", stall_o, busy_o);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || hi_o !== 32'hAA || lo_o !== 32'hAA) begin
      n_fail++;
      $display("FAIL flush_abort: busy=%b hi=%h lo=%h expected 0/aa/aa", busy_o, hi_o, lo_o);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
    end
    n_tests++;
    if (busy_o !== 1'b0 || hi_o !== 32'hAA || lo_o !== 32'hAA) begin
      n_fail++;
      $display("FAIL flush_late: busy=%b hi=%h lo=%h expected 0/aa/aa", busy_o, hi_o, lo_o);
    end
    // A move and a divide start each issued alongside flush are both suppressed.
    @(negedge clk);
    flush = 1'b1;
    hl_we = 1'b1;
    funct = F_MTHI;
    src_a = 32'h55;
    @(negedge clk);
    funct = F_DIVU;
    src_b = 32'd3;
    #1;
    n_tests++;
    if (hi_o !== 32'hAA || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_op: hi=%h stall=%b expected aa/0", hi_o, stall_o);
    end
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    flush = 1'b0;
    #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_reset_mid_div();
    drive(1'b1, F_DIVU, 32'd1000, 32'd3);
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
    end
    resetn = 1'b0;
    #1;
    n_tests++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || busy_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b stall=%b expected 0/0/0/0", hi_o, lo_o, busy_o, stall_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, F_MTLO, 32'd1, 32'h0);
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    n_tests++;
    if (lo_o !== 32'd1 || hi_o !== 32'h0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover: lo=%h hi=%h busy=%b expected 1/0/0", lo_o, hi_o, busy_o);
    end
  endtask

  initial begin
    resetn = 1'b0;
    hl_we  = 1'b0;
    funct  = 6'h00;
    src_a  = 32'h0;
    src_b  = 32'h0;
    flush  = 1'b0;
    test_reset();
    test_moves();
    test_multiply();
    test_divide();
    test_div_corners();
    test_flush();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
